mux_nx1_rr: RTL
===============

Name: mux_nx1_rr

Overview:
- Parametrised N-channel, WIDTH-bit selector with a registered output and valid/ready handshake on every port.
- Two modes:
  - Manual: channel picked by `sel`.
  - Round-robin: fair scan over requesting channels.
- Next-generation datapath mux for lab designs that merge several streamed sources into one consumer.
- Output is registered, giving one cycle of latency and backpressure support.

Parameters:
- WIDTH, 8, data width per channel (>=1).
- N_CH, 4, number of input channels (>=2; non-power-of-two allowed).
- SEL_W, $clog2(N_CH), derived localparam; width of `sel`, `out_ch` and the RR pointer. Not to be overridden.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- mode  input  1  0 = manual, 1 = round-robin
- sel  input  SEL_W  manual-mode channel index
- in_data  input  N_CH*WIDTH  flattened inputs; channel k occupies bits [k*WIDTH +: WIDTH]
- in_valid  input  N_CH  per-channel request
- in_ready  output  N_CH  one-hot grant/accept; all-zero when nothing is accepted
- out_data  output  WIDTH  registered selected data
- out_ch  output  SEL_W  channel index of the current `out_data`
- out_valid  output  1  `out_data` holds a valid word
- out_ready  input  1  consumer accepts `out_data`

Behaviour:
- Reset (async, rst=1): out_data=0, out_ch=0, out_valid=0, ptr=0, in_ready=0 (forced combinationally while rst=1). Reset mid-transfer discards the held word, and that word is not re-presented after reset.
- load_en = !out_valid | out_ready. A word is accepted in the same cycle the previous one drains, so throughput is 1 word/clk.
- Grant (combinational, evaluated each cycle):
  - Manual: gnt = sel, only when sel < N_CH and in_valid[sel]=1. Otherwise no grant. sel >= N_CH never grants.
  - Round-robin: gnt = first k with in_valid[k]=1, searching ptr, ptr+1, ..., N_CH-1, 0, ..., ptr-1 (wraps at N_CH, not at 2^SEL_W). No grant if in_valid = 0.
- in_ready[gnt] = load_en when a grant exists; all other bits 0.
- A transfer occurs on a clock edge with in_valid[k] & in_ready[k]. On that edge:
  - out_data <= channel k data; out_ch <= k; out_valid <= 1
  - ptr <= (k == N_CH-1) ? 0 : k+1
  - ptr updates in both modes.
- If load_en=1 and no grant: out_valid <= 0; out_data/out_ch hold their last value (don't-care for the consumer).
- If load_en=0 (out_valid=1, out_ready=0): out_data, out_ch and out_valid hold, all in_ready=0, ptr holds.
- Latency: input accepted at edge t appears on out_data after edge t, i.e. 1 cycle.
- Mode or sel change takes effect on the next grant evaluation; the held output word is never altered.
- Inputs are not required to hold in_valid while unaccepted. The block only samples on a transfer.
- No combinational path from in_data to out_data. in_ready depends combinationally on in_valid, mode, sel, ptr, out_valid and out_ready.

Decomposition:
- Shared include file: MODE_MANUAL=1'b0 and MODE_RR=1'b1 constants, plus a clog2 helper if the toolchain lacks $clog2.
- Natural sub-module: rr_arbiter #(N_CH).
  - Inputs: req[N_CH], ptr[SEL_W].
  - Outputs: gnt_idx[SEL_W], gnt_any.
  - Purely combinational rotate-priority search.
- Top level: manual/RR grant select, in_ready decode, input slice mux, output register and ptr register.

Test Plan:
1. Reset: assert rst mid-stream with out_valid=1 and in_valid=4'b1111 -> out_valid=0, out_data=0, out_ch=0, in_ready=0 immediately (before the next clk edge). After release, the first RR grant goes to ch0.
2. Manual mode, WIDTH=8, N_CH=4:
   - in_data = {8'hD3,8'hC2,8'hB1,8'hA0}, in_valid=4'b1111, sel=2, out_ready=1 -> in_ready=4'b0100; next cycle out_data=8'hC2, out_ch=2, out_valid=1.
   - Then in_valid[2]=0 -> in_ready=0 and out_valid drops to 0 after 1 edge.
3. RR fairness: mode=1, in_valid=4'b1011 held, out_ready=1 for 6 cycles -> out_ch sequence 0,1,3,0,1,3 with no gaps in out_valid.
4. Backpressure: RR, in_valid=4'b1111, out_ready=0 for 3 cycles after the first word (ch0) -> out_data/out_ch frozen at ch0, in_ready=0 throughout. On out_ready=1 -> ch1 is accepted the same cycle and appears the next cycle.
5. Non-power-of-two: N_CH=3, sel=3 in manual -> no grant, out_valid=0. RR with in_valid=3'b100 then 3'b011 -> grants ch2, then ch0 (ptr wraps 2->0), then ch1.
6. Mode switch: RR grants ch1 (ptr=2), switch to manual with sel=0 -> next output is ch0. Switch back to RR with all valid -> next grant is ch1 (ptr=1 after the ch0 transfer).

Source files
------------

// File: rtl/mux_nx1_rr_pkg.sv
// Shared constants for the N-to-1 round-robin/manual stream selector.
package mux_nx1_rr_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_RR     = 1'b1;

endpackage

// File: rtl/mux_nx1_rr_arbiter.sv
// Rotate-priority request search: the first requester at or after ptr wins,
// wrapping at N_CH (not at 2^SEL_W) so non-power-of-two channel counts work.
module mux_nx1_rr_arbiter #(
  parameter  int N_CH  = 4,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] gnt_idx,
  output logic             gnt_any
);

  logic [SEL_W:0] cand;

  // Scan offsets from farthest to nearest so the nearest requester overwrites.
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    cand    = '0;
    for (int off = N_CH - 1; off >= 0; off--) begin
      cand = {1'b0, ptr} + (SEL_W + 1)'(off);
      if (cand >= (SEL_W + 1)'(N_CH)) begin
        cand = cand - (SEL_W + 1)'(N_CH);
      end
      if (req[cand[SEL_W-1:0]]) begin
        gnt_idx = cand[SEL_W-1:0];
        gnt_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_nx1_rr.sv
// N-channel selector with registered output and valid/ready on every port.
// Manual mode forwards the channel named by sel; round-robin mode scans
// requesters starting after the most recently accepted channel.
module mux_nx1_rr
  import mux_nx1_rr_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int N_CH  = 4,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      sel,
  input  logic [N_CH*WIDTH-1:0] in_data,
  input  logic [N_CH-1:0]       in_valid,
  output logic [N_CH-1:0]       in_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [SEL_W-1:0]      out_ch,
  output logic                  out_valid,
  input  logic                  out_ready
);

  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] arb_idx;
  logic             arb_any;
  logic [SEL_W-1:0] gnt_idx;
  logic             gnt_any;
  logic             load_en;
  logic             sel_ok;
  logic [SEL_W-1:0] ptr_next;
  logic [WIDTH-1:0] ch_data [N_CH];

  for (genvar k = 0; k < N_CH; k++) begin : g_slice
    assign ch_data[k] = in_data[k*WIDTH +: WIDTH];
  end

  mux_nx1_rr_arbiter #(.N_CH(N_CH)) u_arb (
    .req     (in_valid),
    .ptr     (ptr),
    .gnt_idx (arb_idx),
    .gnt_any (arb_any)
  );

  // The output register can take a new word when empty or draining this cycle.
  assign load_en  = !out_valid || out_ready;
  assign sel_ok   = ({1'b0, sel} < (SEL_W + 1)'(N_CH));
  assign ptr_next = ({1'b0, gnt_idx} == (SEL_W + 1)'(N_CH - 1)) ? '0 : gnt_idx + SEL_W'(1);

  // Choose between the round-robin winner and the manually selected channel.
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    if (mode == MODE_RR) begin
      gnt_idx = arb_idx;
      gnt_any = arb_any;
    end else if (sel_ok && in_valid[sel]) begin
      gnt_idx = sel;
      gnt_any = 1'b1;
    end
  end

  // One-hot accept; held low during reset so no word slips in while clearing.
  always_comb begin
    in_ready = '0;
    if (!rst && gnt_any && load_en) begin
      in_ready[gnt_idx] = 1'b1;
    end
  end

  // Output word register and rotation pointer; data/channel hold when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data  <= '0;
      out_ch    <= '0;
      out_valid <= 1'b0;
      ptr       <= '0;
    end else if (load_en) begin
      if (gnt_any) begin
        out_data  <= ch_data[gnt_idx];
        out_ch    <= gnt_idx;
        out_valid <= 1'b1;
        ptr       <= ptr_next;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
